// File: rtl/scudsp_prg_loader_if.sv
// Host register and DMA program-word bus between the SCU register block and the
// SCU DSP program loader.
interface scudsp_prg_loader_if;
  logic        host_wr;
  logic        host_rd;
  logic        host_a;
  logic [31:0] host_di;
  logic [31:0] host_do;
  logic        dma_prgw;
  logic [31:0] dma_di;

  modport master (
    output host_wr, host_rd, host_a, host_di, dma_prgw, dma_di,
    input  host_do
  );

  modport slave (
    input  host_wr, host_rd, host_a, host_di, dma_prgw, dma_di,
    output host_do
  );
endinterface

// File: rtl/scudsp_prg_loader.sv
// SCU DSP program loader: fills program RAM from host and DMA words and runs the
// stop/run/step control FSM of the DSP sequencer.
module scudsp_prg_loader #(
  parameter int PRG_AW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  scudsp_prg_loader_if.slave    bus,
  input  logic                  dsp_end,
  input  logic                  dsp_ei,
  output logic                  prg_we,
  output logic [PRG_AW-1:0]     prg_wa,
  output logic [31:0]           prg_wd,
  output logic                  pc_load,
  output logic [PRG_AW-1:0]     pc_val,
  output logic                  run,
  output logic                  step,
  output logic                  end_irq
);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_STEP} state_t;

  state_t              state_reg;
  logic [PRG_AW-1:0]   lp_reg;
  logic                hb_valid_reg;
  logic [31:0]         hb_data_reg;
  logic                e_reg, w_reg, o_reg;
  logic                prg_we_reg;
  logic [PRG_AW-1:0]   prg_wa_reg;
  logic [31:0]         prg_wd_reg;
  logic                pc_load_reg;
  logic [PRG_AW-1:0]   pc_val_reg;
  logic                end_irq_reg;

  logic ppaf_wr, ppd_wr, stat_rd;
  logic fld_le, fld_ex, fld_es;

  always_comb begin
    ppaf_wr = bus.host_wr && !bus.host_a;
    ppd_wr  = bus.host_wr &&  bus.host_a;
    stat_rd = bus.host_rd && !bus.host_a;
    fld_le  = bus.host_di[15];
    fld_ex  = bus.host_di[16];
    fld_es  = bus.host_di[17];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_STOP;
      lp_reg       <= '0;
      hb_valid_reg <= 1'b0;
      hb_data_reg  <= '0;
      e_reg        <= 1'b0;
      w_reg        <= 1'b0;
      o_reg        <= 1'b0;
      prg_we_reg   <= 1'b0;
      prg_wa_reg   <= '0;
      prg_wd_reg   <= '0;
      pc_load_reg  <= 1'b0;
      pc_val_reg   <= '0;
      end_irq_reg  <= 1'b0;
    end else if (ce) begin
      prg_we_reg  <= 1'b0;
      pc_load_reg <= 1'b0;
      end_irq_reg <= 1'b0;

      // Clears come first so that a set event later in this block wins.
      if (stat_rd) begin
        e_reg <= 1'b0;
        w_reg <= 1'b0;
        o_reg <= 1'b0;
      end

      if (bus.dma_prgw) begin
        prg_we_reg <= 1'b1;
        prg_wa_reg <= lp_reg;
        prg_wd_reg <= bus.dma_di;
        lp_reg     <= lp_reg + PRG_AW'(1);
      end else if (hb_valid_reg) begin
        prg_we_reg   <= 1'b1;
        prg_wa_reg   <= lp_reg;
        prg_wd_reg   <= hb_data_reg;
        lp_reg       <= lp_reg + PRG_AW'(1);
        hb_valid_reg <= 1'b0;
      end

      // HB is only full after this cycle if DMA kept it from committing.
      if (ppd_wr) begin
        if (state_reg != ST_STOP) begin
          w_reg <= 1'b1;
        end else if (hb_valid_reg && bus.dma_prgw) begin
          o_reg <= 1'b1;
        end else begin
          hb_valid_reg <= 1'b1;
          hb_data_reg  <= bus.host_di;
        end
      end

      // A load overrides the increment from a same-cycle RAM write.
      if (ppaf_wr && fld_le) begin
        lp_reg      <= bus.host_di[PRG_AW-1:0];
        pc_load_reg <= 1'b1;
        pc_val_reg  <= bus.host_di[PRG_AW-1:0];
      end

      case (state_reg)
        ST_STOP: begin
          if (ppaf_wr && fld_ex)
            state_reg <= ST_RUN;
          else if (ppaf_wr && fld_es)
            state_reg <= ST_STEP;
        end
        ST_RUN: begin
          if (dsp_end || (ppaf_wr && !fld_ex))
            state_reg <= ST_STOP;
        end
        ST_STEP: begin
          state_reg <= (ppaf_wr && fld_ex) ? ST_RUN : ST_STOP;
        end
        default: state_reg <= ST_STOP;
      endcase

      if (dsp_end && (state_reg != ST_STOP)) begin
        e_reg       <= 1'b1;
        end_irq_reg <= dsp_ei;
      end
    end
  end

  always_comb begin
    bus.host_do             = '0;
    bus.host_do[23]         = w_reg;
    bus.host_do[22]         = o_reg;
    bus.host_do[21]         = hb_valid_reg;
    bus.host_do[18]         = e_reg;
    bus.host_do[17]         = (state_reg == ST_STEP);
    bus.host_do[16]         = (state_reg == ST_RUN);
    bus.host_do[PRG_AW-1:0] = lp_reg;
  end

  assign prg_we  = prg_we_reg;
  assign prg_wa  = prg_wa_reg;
  assign prg_wd  = prg_wd_reg;
  assign pc_load = pc_load_reg;
  assign pc_val  = pc_val_reg;
  assign run     = (state_reg == ST_RUN);
  assign step    = (state_reg == ST_STEP);
  assign end_irq = end_irq_reg;

endmodule

// File: tb/tb_scudsp_prg_loader.sv
// Directed bench for scudsp_prg_loader: program loading, write arbitration,
// run/step control, end handling, status clear, clock enable and reset.
module tb_scudsp_prg_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b1;
  logic        dsp_end = 1'b0;
  logic        dsp_ei  = 1'b0;
  logic        prg_we;
  logic [7:0]  prg_wa;
  logic [31:0] prg_wd;
  logic        pc_load;
  logic [7:0]  pc_val;
  logic        run, step, end_irq;

  int total = 0;
  int bad   = 0;

  scudsp_prg_loader_if bus ();

  scudsp_prg_loader #(.PRG_AW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .bus     (bus),
    .dsp_end (dsp_end),
    .dsp_ei  (dsp_ei),
    .prg_we  (prg_we),
    .prg_wa  (prg_wa),
    .prg_wd  (prg_wd),
    .pc_load (pc_load),
    .pc_val  (pc_val),
    .run     (run),
    .step    (step),
    .end_irq (end_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic a, input logic [31:0] d);
    bus.host_wr = 1'b1;
    bus.host_a  = a;
    bus.host_di = d;
    tick();
    bus.host_wr = 1'b0;
    bus.host_di = '0;
  endtask

  task automatic chk_wr(input string tag, input logic [7:0] a, input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, prg_we}, 32'd1);
    chk({tag, "_wa"}, {24'd0, prg_wa}, {24'd0, a});
    chk({tag, "_wd"}, prg_wd, d);
  endtask

  initial begin
    logic [7:0] wrap_a [3];
    wrap_a = '{8'hFE, 8'hFF, 8'h00};
    bus.host_wr = 1'b0; bus.host_rd = 1'b0; bus.host_a = 1'b0; bus.host_di = '0;
    bus.dma_prgw = 1'b0; bus.dma_di = '0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_do", bus.host_do, 32'h0);
    chk("rst_outs", {26'd0, prg_we, pc_load, run, step, end_irq, 1'b0}, 32'h0);
    chk("rst_pcval", {24'd0, pc_val}, 32'h0);

    // Load LP/PC to 0x10, then four back-to-back PPD words
    host_write(1'b0, 32'h0000_8010);
    chk("t1_pcload", {31'd0, pc_load}, 32'd1);
    chk("t1_pcval", {24'd0, pc_val}, 32'h10);
    chk("t1_lp", bus.host_do, 32'h0000_0010);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        bus.host_wr = 1'b1; bus.host_a = 1'b1; bus.host_di = 32'hA500_0000 + 32'(i);
      end else begin
        bus.host_wr = 1'b0;
      end
      tick();
      if (i == 0) begin
        chk("t1_pcload_end", {31'd0, pc_load}, 32'd0);
        chk("t1_we0", {31'd0, prg_we}, 32'd0);
      end else if (i <= 4) begin
        chk_wr($sformatf("t1_w%0d", i - 1), 8'(8'h10 + i - 1), 32'hA500_0000 + 32'(i - 1));
      end else begin
        chk("t1_we_idle", {31'd0, prg_we}, 32'd0);
      end
    end
    chk("t1_do", bus.host_do, 32'h0000_0014);

    // Wrap of the load pointer
    host_write(1'b0, 32'h0000_80FE);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        bus.host_wr = 1'b1; bus.host_a = 1'b1; bus.host_di = 32'hB000_0000 + 32'(i);
      end else begin
        bus.host_wr = 1'b0;
      end
      tick();
      if (i >= 1) chk_wr($sformatf("t2_w%0d", i - 1), wrap_a[i-1], 32'hB000_0000 + 32'(i - 1));
    end
    tick();
    chk("t2_do", bus.host_do, 32'h0000_0001);

    // DMA has priority; host word waits in HB; second PPD overflows
    bus.dma_prgw = 1'b1; bus.dma_di = 32'hD000_0000;
    bus.host_wr = 1'b1; bus.host_a = 1'b1; bus.host_di = 32'hC0DE_0001;
    tick();
    chk_wr("t3_d0", 8'h01, 32'hD000_0000);
    chk("t3_do1", bus.host_do, 32'h0020_0002);
    bus.dma_di = 32'hD000_0001; bus.host_di = 32'hC0DE_0002;
    tick();
    chk_wr("t3_d1", 8'h02, 32'hD000_0001);
    chk("t3_ovf", bus.host_do, 32'h0060_0003);
    bus.host_wr = 1'b0; bus.dma_di = 32'hD000_0002;
    tick();
    chk_wr("t3_d2", 8'h03, 32'hD000_0002);
    bus.dma_prgw = 1'b0;
    tick();
    chk_wr("t3_hb", 8'h04, 32'hC0DE_0001);
    tick();
    chk("t3_we_idle", {31'd0, prg_we}, 32'd0);
    chk("t3_do2", bus.host_do, 32'h0040_0005);
    bus.host_rd = 1'b1; bus.host_a = 1'b0;
    tick();
    bus.host_rd = 1'b0;
    chk("t3_clr", bus.host_do, 32'h0000_0005);

    // Run, dropped PPD, ENDI
    host_write(1'b0, 32'h0001_0000);
    chk("t4_run", {31'd0, run}, 32'd1);
    host_write(1'b1, 32'h0000_DEAD);
    chk("t4_w", bus.host_do, 32'h0081_0005);
    tick();
    chk("t4_nowr", {31'd0, prg_we}, 32'd0);
    dsp_end = 1'b1; dsp_ei = 1'b1;
    tick();
    dsp_end = 1'b0; dsp_ei = 1'b0;
    chk("t4_irq", {30'd0, run, end_irq}, 32'b01);
    chk("t4_e", bus.host_do, 32'h0084_0005);
    bus.host_rd = 1'b1; bus.host_a = 1'b0;
    #1;
    chk("t4_rd", bus.host_do, 32'h0084_0005);
    tick();
    bus.host_rd = 1'b0;
    chk("t4_irq_end", {31'd0, end_irq}, 32'd0);
    chk("t4_clr", bus.host_do, 32'h0000_0005);

    // Single step, END in STOP ignored, ES with EX
    host_write(1'b0, 32'h0002_0000);
    chk("t5_step", {30'd0, run, step}, 32'b01);
    chk("t5_do", bus.host_do, 32'h0002_0005);
    tick();
    chk("t5_stop", {30'd0, run, step}, 32'b00);
    chk("t5_do2", bus.host_do, 32'h0000_0005);
    dsp_end = 1'b1; dsp_ei = 1'b1;
    tick();
    dsp_end = 1'b0; dsp_ei = 1'b0;
    chk("t5_end_ign", {31'd0, end_irq}, 32'd0);
    chk("t5_e_ign", bus.host_do, 32'h0000_0005);
    host_write(1'b0, 32'h0003_0000);
    chk("t5_exes", {30'd0, run, step}, 32'b10);
    tick();
    chk("t5_exes2", {30'd0, run, step}, 32'b10);

    // Reset with HB pending and RUN high
    host_write(1'b0, 32'h0000_0000);
    chk("t6_stop", {31'd0, run}, 32'd0);
    bus.dma_prgw = 1'b1; bus.dma_di = 32'hE000_0000;
    bus.host_wr = 1'b1; bus.host_a = 1'b1; bus.host_di = 32'hF00D_0001;
    tick();
    chk_wr("t6_d0", 8'h05, 32'hE000_0000);
    bus.dma_di = 32'hE000_0001; bus.host_a = 1'b0; bus.host_di = 32'h0001_0000;
    tick();
    chk("t6_pend", bus.host_do, 32'h0021_0007);
    rst = 1'b1; bus.dma_prgw = 1'b0; bus.host_wr = 1'b0; bus.host_di = '0;
    tick();
    rst = 1'b0;
    chk("t6_rst_do", bus.host_do, 32'h0);
    chk("t6_rst_outs", {26'd0, prg_we, pc_load, run, step, end_irq, 1'b0}, 32'h0);
    chk("t6_rst_bus", {prg_wa, pc_val, 16'd0} | prg_wd, 32'h0);
    tick();
    chk("t6_nowr", {31'd0, prg_we}, 32'd0);
    chk("t6_do", bus.host_do, 32'h0);

    // Clock enable holds pulses and blocks inputs
    host_write(1'b0, 32'h0000_8020);
    ce = 1'b0;
    bus.dma_prgw = 1'b1; bus.dma_di = 32'h1234_5678;
    bus.host_wr = 1'b1; bus.host_a = 1'b1; bus.host_di = 32'h8765_4321;
    tick();
    chk("t7_hold", {31'd0, pc_load}, 32'd1);
    chk("t7_do", bus.host_do, 32'h0000_0020);
    ce = 1'b1; bus.dma_prgw = 1'b0; bus.host_wr = 1'b0;
    tick();
    chk("t7_pulse_end", {30'd0, pc_load, prg_we}, 32'd0);
    chk("t7_do2", bus.host_do, 32'h0000_0020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
